// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Pops Dsize-bit words from a show-ahead FIFO and packs LANES of them into
//   one output word. A partial word can be emitted early with flush. The
//   first popped byte lands in the least-significant lane, and unfilled lanes
//   read as zero.
//
// Ports
//   rclk        clock (FIFO read domain)
//   r_rst       asynchronous active-low reset
//   rd_data     FIFO read data, valid while rempty is low
//   rempty      FIFO empty flag
//   rinc        FIFO pop request (combinational)
//   flush       level request to emit a partially filled word
//   out_data    packed output word
//   out_nbytes  number of valid lanes in out_data (1..LANES when valid)
//   out_valid   out_data / out_nbytes valid
//   out_ready   downstream accept; transfer on out_valid && out_ready
module fifo_rd_packer #(
    parameter int Dsize = 8,
    parameter int LANES = 4
) (
    input  logic                       rclk,
    input  logic                       r_rst,
    input  logic [Dsize-1:0]           rd_data,
    input  logic                       rempty,
    output logic                       rinc,
    input  logic                       flush,
    output logic [Dsize*LANES-1:0]     out_data,
    output logic [$clog2(LANES):0]     out_nbytes,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int CW = $clog2(LANES);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [Dsize*LANES-1:0]  lanes_q, lanes_d;
    logic [CW:0]             nbytes_q, nbytes_d;
    logic                    valid_q, valid_d;

    logic pop;
    logic last_lane;
    logic flush_emit;
    logic xfer;

    // Gating with r_rst keeps the FIFO from popping while reset is held.
    assign rinc       = r_rst && (state_q == FILL) && !rempty;
    assign pop        = rinc;
    assign last_lane  = (cnt_q == CW'(LANES - 1));
    // Flush with nothing collected and no byte arriving is ignored.
    assign flush_emit = flush && (pop || (cnt_q != '0));
    assign xfer       = (state_q == HOLD) && out_ready;

    // State register
    always_ff @(posedge rclk or negedge r_rst) begin
        if (!r_rst) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            lanes_q  <= '0;
            nbytes_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lanes_q  <= lanes_d;
            nbytes_q <= nbytes_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if ((pop && last_lane) || flush_emit) state_d = HOLD;
            HOLD: if (out_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        cnt_d    = cnt_q;
        lanes_d  = lanes_q;
        nbytes_d = nbytes_q;
        valid_d  = valid_q;
        if (state_q == FILL) begin
            if (pop) begin
                lanes_d[cnt_q*Dsize +: Dsize] = rd_data;
            end
            if ((pop && last_lane) || flush_emit) begin
                // Emitted count includes a byte popped on this same edge.
                valid_d  = 1'b1;
                nbytes_d = {1'b0, cnt_q} + (CW+1)'(pop);
                cnt_d    = '0;
            end else if (pop) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (xfer) begin
            // Clearing lanes here is what keeps stale bytes out of later words.
            cnt_d    = '0;
            lanes_d  = '0;
            nbytes_d = '0;
            valid_d  = 1'b0;
        end
    end

    assign out_data   = lanes_q;
    assign out_nbytes = nbytes_q;
    assign out_valid  = valid_q;

endmodule
